// File: rtl/ysyx_22050710_mem_stage.sv
// Memory-access pipeline stage: latches the execute bus, runs one data-memory
// request/response for loads and stores, aligns/extends load data for write-back.
module ysyx_22050710_mem_stage #(
  parameter int WORD_WD         = 64,
  parameter int GPR_ADDR_WD     = 5,
  parameter int CSR_ADDR_WD     = 12,
  parameter int ES_TO_MS_BUS_WD = 2 + 3 + WORD_WD + 1 + GPR_ADDR_WD + WORD_WD + 1 + CSR_ADDR_WD + WORD_WD,
  parameter int MS_TO_WS_BUS_WD = 1 + GPR_ADDR_WD + WORD_WD + 1 + CSR_ADDR_WD + WORD_WD,
  parameter int DEBUG_BUS_WD    = 1 + 32 + WORD_WD + WORD_WD + 1 + WORD_WD
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] i_es_to_ms_bus,
  output logic                       o_ms_allowin,
  input  logic                       i_ws_allowin,
  output logic                       o_ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] o_ms_to_ws_bus,
  output logic [GPR_ADDR_WD-1:0]     o_ms_to_ds_gpr_rd,
  output logic [CSR_ADDR_WD-1:0]     o_ms_to_ds_csr_rd,
  output logic                       o_dmem_req_valid,
  input  logic                       i_dmem_req_ready,
  output logic                       o_dmem_req_wen,
  output logic [WORD_WD-1:0]         o_dmem_addr,
  output logic [WORD_WD-1:0]         o_dmem_wdata,
  output logic [7:0]                 o_dmem_wmask,
  input  logic                       i_dmem_rsp_valid,
  output logic                       o_dmem_rsp_ready,
  input  logic [WORD_WD-1:0]         i_dmem_rdata,
  input  logic [DEBUG_BUS_WD-1:0]    i_debug_es_to_ms_bus,
  output logic [DEBUG_BUS_WD-1:0]    o_debug_ms_to_ws_bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic                       r_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] r_es_to_ms_bus;
  logic [DEBUG_BUS_WD-1:0]    r_debug_bus;
  logic [WORD_WD-1:0]         r_load_data;

  logic                   w_mem_ren;
  logic                   w_mem_wen;
  logic [2:0]             w_funct3;
  logic [WORD_WD-1:0]     w_store_data;
  logic                   w_gpr_wen;
  logic [GPR_ADDR_WD-1:0] w_rd;
  logic [WORD_WD-1:0]     w_alu_result;
  logic                   w_csr_wen;
  logic [CSR_ADDR_WD-1:0] w_csr;
  logic [WORD_WD-1:0]     w_csr_result;

  logic                   w_mem_op;
  logic                   w_in_mem_op;
  logic                   w_ready_go;
  logic                   w_latch;
  logic                   w_capture;
  logic [2:0]             w_off;
  logic [5:0]             w_bit_shift;
  logic [7:0]             w_size_mask;
  logic [WORD_WD-1:0]     w_load_shifted;
  logic [WORD_WD-1:0]     w_load_ext;
  logic [WORD_WD-1:0]     w_gpr_final;

  assign {w_mem_ren, w_mem_wen, w_funct3, w_store_data, w_gpr_wen, w_rd,
          w_alu_result, w_csr_wen, w_csr, w_csr_result} = r_es_to_ms_bus;

  assign w_in_mem_op = i_es_to_ms_bus[ES_TO_MS_BUS_WD-1] | i_es_to_ms_bus[ES_TO_MS_BUS_WD-2];
  assign w_mem_op    = w_mem_ren | w_mem_wen;
  assign w_ready_go  = !w_mem_op || (r_state == S_DONE);

  assign o_ms_allowin     = !r_ms_valid || (w_ready_go && i_ws_allowin);
  assign o_ms_to_ws_valid = r_ms_valid && w_ready_go;
  assign w_latch          = i_es_to_ms_valid && o_ms_allowin;
  assign w_capture        = (r_state == S_WAIT) && i_dmem_rsp_valid;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ms_valid     <= 1'b0;
      r_es_to_ms_bus <= '0;
      r_debug_bus    <= '0;
      r_load_data    <= '0;
    end else begin
      if (o_ms_allowin) begin
        r_ms_valid <= i_es_to_ms_valid;
      end
      if (w_latch) begin
        r_es_to_ms_bus <= i_es_to_ms_bus;
        r_debug_bus    <= i_debug_es_to_ms_bus;
      end
      if (w_capture) begin
        r_load_data <= i_dmem_rdata;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Whatever edge admits a new instruction (or bubble) restarts the FSM; a
  // mem op in flight blocks allowin, so it can never be interrupted here.
  always_comb begin
    w_state_next = r_state;
    if (o_ms_allowin) begin
      w_state_next = (i_es_to_ms_valid && w_in_mem_op) ? S_REQ : S_IDLE;
    end else begin
      case (r_state)
        S_REQ:   if (i_dmem_req_ready) w_state_next = S_WAIT;
        S_WAIT:  if (i_dmem_rsp_valid) w_state_next = S_DONE;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_comb begin
    o_dmem_req_valid = (r_state == S_REQ);
    o_dmem_rsp_ready = (r_state == S_WAIT);
  end

  assign w_off       = w_alu_result[2:0];
  assign w_bit_shift = {w_off, 3'b000};

  always_comb begin
    case (w_funct3[1:0])
      2'b00:   w_size_mask = 8'h01;
      2'b01:   w_size_mask = 8'h03;
      2'b10:   w_size_mask = 8'h0F;
      default: w_size_mask = 8'hFF;
    endcase
  end

  assign o_dmem_req_wen = w_mem_wen;
  assign o_dmem_addr    = w_alu_result;
  assign o_dmem_wdata   = w_store_data << w_bit_shift;
  assign o_dmem_wmask   = w_mem_wen ? (w_size_mask << w_off) : 8'h00;

  assign w_load_shifted = r_load_data >> w_bit_shift;

  always_comb begin
    case (w_funct3)
      3'b000:  w_load_ext = {{(WORD_WD-8){w_load_shifted[7]}},   w_load_shifted[7:0]};
      3'b001:  w_load_ext = {{(WORD_WD-16){w_load_shifted[15]}}, w_load_shifted[15:0]};
      3'b010:  w_load_ext = {{(WORD_WD-32){w_load_shifted[31]}}, w_load_shifted[31:0]};
      3'b100:  w_load_ext = {{(WORD_WD-8){1'b0}},  w_load_shifted[7:0]};
      3'b101:  w_load_ext = {{(WORD_WD-16){1'b0}}, w_load_shifted[15:0]};
      3'b110:  w_load_ext = {{(WORD_WD-32){1'b0}}, w_load_shifted[31:0]};
      default: w_load_ext = w_load_shifted;
    endcase
  end

  assign w_gpr_final    = w_mem_ren ? w_load_ext : w_alu_result;
  assign o_ms_to_ws_bus = {w_gpr_wen, w_rd, w_gpr_final, w_csr_wen, w_csr, w_csr_result};

  assign o_ms_to_ds_gpr_rd    = (r_ms_valid && w_gpr_wen) ? w_rd  : '0;
  assign o_ms_to_ds_csr_rd    = (r_ms_valid && w_csr_wen) ? w_csr : '0;
  assign o_debug_ms_to_ws_bus = r_debug_bus;

endmodule

// File: tb/tb_ysyx_22050710_mem_stage.sv
// Scoreboard bench for the memory stage: directed ops push expected results and
// requests; a memory responder and an output monitor pop and compare them.
module tb_ysyx_22050710_mem_stage;
  localparam int WW  = 64;
  localparam int ES  = 2 + 3 + WW + 1 + 5 + WW + 1 + 12 + WW;
  localparam int MS  = 1 + 5 + WW + 1 + 12 + WW;
  localparam int DBG = 1 + 32 + WW + WW + 1 + WW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           es_valid;
  logic [ES-1:0]  es_bus;
  logic           ms_allowin;
  logic           ws_allowin;
  logic           ms_to_ws_valid;
  logic [MS-1:0]  ms_to_ws_bus;
  logic [4:0]     gpr_rd;
  logic [11:0]    csr_rd;
  logic           req_valid;
  logic           req_ready;
  logic           req_wen;
  logic [WW-1:0]  addr;
  logic [WW-1:0]  wdata;
  logic [7:0]     wmask;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [WW-1:0]  rdata;
  logic [DBG-1:0] dbg_in;
  logic [DBG-1:0] dbg_out;

  always #5 clk = ~clk;

  ysyx_22050710_mem_stage dut (
    .i_clk               (clk),
    .i_rst               (rst_n),
    .i_es_to_ms_valid    (es_valid),
    .i_es_to_ms_bus      (es_bus),
    .o_ms_allowin        (ms_allowin),
    .i_ws_allowin        (ws_allowin),
    .o_ms_to_ws_valid    (ms_to_ws_valid),
    .o_ms_to_ws_bus      (ms_to_ws_bus),
    .o_ms_to_ds_gpr_rd   (gpr_rd),
    .o_ms_to_ds_csr_rd   (csr_rd),
    .o_dmem_req_valid    (req_valid),
    .i_dmem_req_ready    (req_ready),
    .o_dmem_req_wen      (req_wen),
    .o_dmem_addr         (addr),
    .o_dmem_wdata        (wdata),
    .o_dmem_wmask        (wmask),
    .i_dmem_rsp_valid    (rsp_valid),
    .o_dmem_rsp_ready    (rsp_ready),
    .i_dmem_rdata        (rdata),
    .i_debug_es_to_ms_bus(dbg_in),
    .o_debug_ms_to_ws_bus(dbg_out)
  );

  typedef struct {
    logic [MS-1:0]  bus;
    logic [DBG-1:0] dbg;
    logic [4:0]     gpr_rd;
    logic [11:0]    csr_rd;
  } out_t;

  typedef struct {
    logic [WW-1:0] addr;
    logic          wen;
    logic [WW-1:0] wdata;
    logic [7:0]    wmask;
    logic [WW-1:0] rdata;
  } req_t;

  out_t out_q[$];
  req_t req_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_tx  = 0;
  int   mem_req_wait = 0;
  bit   mem_hold_rsp = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Memory responder: req_ready after mem_req_wait stalled cycles, response the cycle after.
  initial begin : mem_model
    int   wait_cnt;
    req_t cur;
    wait_cnt  = 0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rdata     = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        wait_cnt  = 0;
        continue;
      end
      if (rsp_valid) rsp_valid = 1'b0;
      if (req_ready) begin
        req_ready = 1'b0;
        if (!mem_hold_rsp) begin
          rsp_valid = 1'b1;
          rdata     = cur.rdata;
        end
      end else if (req_valid) begin
        chk("req_blocks_allowin", 256'(ms_allowin), 256'(0));
        chk("req_no_ws_valid", 256'(ms_to_ws_valid), 256'(0));
        if (req_q.size() == 0) begin
          fail_now("unexpected_dmem_request");
        end else begin
          cur = req_q[0];
          chk("req_addr", 256'(addr), 256'(cur.addr));
          chk("req_wen", 256'(req_wen), 256'(cur.wen));
          if (cur.wen) begin
            chk("req_wdata", 256'(wdata), 256'(cur.wdata));
            chk("req_wmask", 256'(wmask), 256'(cur.wmask));
          end
          if (wait_cnt == mem_req_wait) begin
            void'(req_q.pop_front());
            req_ready = 1'b1;
            wait_cnt  = 0;
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // Output monitor: compares while valid, pops on the transfer cycle.
  initial begin : monitor
    out_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && ms_to_ws_valid) begin
        if (out_q.size() == 0) begin
          fail_now("unexpected_ws_valid");
        end else begin
          e = out_q[0];
          chk("ws_bus", 256'(ms_to_ws_bus), 256'(e.bus));
          chk("ws_debug", 256'(dbg_out), 256'(e.dbg));
          chk("hazard_gpr_rd", 256'(gpr_rd), 256'(e.gpr_rd));
          chk("hazard_csr_rd", 256'(csr_rd), 256'(e.csr_rd));
          if (ws_allowin) void'(out_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [ES-1:0] bus, input logic [DBG-1:0] dbg);
    int cnt;
    cnt = 0;
    @(negedge clk);
    es_valid = 1'b1;
    es_bus   = bus;
    dbg_in   = dbg;
    #1;
    while (!ms_allowin && cnt < 100) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    if (cnt >= 100) fail_now("send_allowin_timeout");
    @(posedge clk);
    #1;
    es_valid = 1'b0;
  endtask

  task automatic op(input string name, input logic ren, input logic wen, input logic [2:0] f3,
                    input logic [WW-1:0] sdata, input logic gwen, input logic [4:0] rd,
                    input logic [WW-1:0] alu, input logic cwen, input logic [11:0] csr,
                    input logic [WW-1:0] cres, input logic [WW-1:0] mem_rdata,
                    input logic [WW-1:0] exp_res, input logic [7:0] exp_mask,
                    input logic [WW-1:0] exp_wdata, input bit want_out);
    out_t          o;
    req_t          r;
    logic [DBG-1:0] dbg;
    n_tx++;
    dbg = DBG'({8{32'hD000_0000 + 32'(n_tx)}});
    if (ren || wen) begin
      r.addr  = alu;
      r.wen   = wen;
      r.wdata = exp_wdata;
      r.wmask = exp_mask;
      r.rdata = mem_rdata;
      req_q.push_back(r);
    end
    if (want_out) begin
      o.bus    = {gwen, rd, exp_res, cwen, csr, cres};
      o.dbg    = dbg;
      o.gpr_rd = gwen ? rd : 5'd0;
      o.csr_rd = cwen ? csr : 12'd0;
      out_q.push_back(o);
    end
    $display("tx %0d %s addr/alu=%h expect result=%h", n_tx, name, alu, exp_res);
    send({ren, wen, f3, sdata, gwen, rd, alu, cwen, csr, cres}, dbg);
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while ((out_q.size() != 0 || req_q.size() != 0) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("drain_out_q_empty", 256'(out_q.size()), 256'(0));
    chk("drain_req_q_empty", 256'(req_q.size()), 256'(0));
  endtask

  initial begin : stim
    int cnt;
    rst_n      = 1'b0;
    es_valid   = 1'b0;
    es_bus     = '0;
    dbg_in     = '0;
    ws_allowin = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_allowin", 256'(ms_allowin), 256'(1));
    chk("rst_ws_valid", 256'(ms_to_ws_valid), 256'(0));
    chk("rst_req_valid", 256'(req_valid), 256'(0));
    chk("rst_rsp_ready", 256'(rsp_ready), 256'(0));
    chk("rst_ws_bus", 256'(ms_to_ws_bus), 256'(0));
    chk("rst_gpr_rd", 256'(gpr_rd), 256'(0));
    chk("rst_csr_rd", 256'(csr_rd), 256'(0));
    chk("rst_debug", 256'(dbg_out), 256'(0));
    chk("rst_wmask", 256'(wmask), 256'(0));
    chk("rst_wen", 256'(req_wen), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    //  name      ren  wen  f3    sdata                   gwen rd  alu                    cwen csr      cres       rdata                   exp_res                 mask   wdata
    op("ADD",    0, 0, 3'b000, 64'h0,                  1, 5,  64'h1234,              0, 12'h0,   64'h0,     64'h0,                  64'h1234,               8'h00, 64'h0, 1);
    op("CSRRW",  0, 0, 3'b001, 64'h0,                  0, 7,  64'h99,                1, 12'h305, 64'hDEAD,  64'h0,                  64'h99,                 8'h00, 64'h0, 1);
    op("LB@3",   1, 0, 3'b000, 64'h0,                  1, 10, 64'h8000_0003,         0, 12'h0,   64'h0,     64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h0, 1);
    op("LBU@3",  1, 0, 3'b100, 64'h0,                  1, 11, 64'h8000_0003,         0, 12'h0,   64'h0,     64'h0000_0000_80FF_0000, 64'h80,                 8'h00, 64'h0, 1);
    op("LB@2",   1, 0, 3'b000, 64'h0,                  1, 10, 64'h8000_0002,         0, 12'h0,   64'h0,     64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0, 1);
    op("LBU@2",  1, 0, 3'b100, 64'h0,                  1, 11, 64'h8000_0002,         0, 12'h0,   64'h0,     64'h0000_0000_80FF_0000, 64'hFF,                 8'h00, 64'h0, 1);
    op("SH@2",   0, 1, 3'b001, 64'hBEEF,               0, 0,  64'h8000_0002,         0, 12'h0,   64'h0,     64'h0,                  64'h8000_0002,          8'h0C, 64'hBEEF_0000, 1);
    op("LH@6",   1, 0, 3'b001, 64'h0,                  1, 12, 64'h8000_0006,         0, 12'h0,   64'h0,     64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001, 8'h00, 64'h0, 1);
    op("LHU@6",  1, 0, 3'b101, 64'h0,                  1, 12, 64'h8000_0006,         0, 12'h0,   64'h0,     64'h8001_0000_0000_0000, 64'h8001,               8'h00, 64'h0, 1);
    op("LW@4",   1, 0, 3'b010, 64'h0,                  1, 14, 64'h8000_0004,         0, 12'h0,   64'h0,     64'hF000_0000_1234_5678, 64'hFFFF_FFFF_F000_0000, 8'h00, 64'h0, 1);
    op("LWU@4",  1, 0, 3'b110, 64'h0,                  1, 14, 64'h8000_0004,         0, 12'h0,   64'h0,     64'hF000_0000_1234_5678, 64'hF000_0000,          8'h00, 64'h0, 1);
    op("SB@7",   0, 1, 3'b000, 64'h1234_5678_9ABC_DEAB, 0, 0,  64'h8000_0007,         0, 12'h0,   64'h0,     64'h0,                  64'h8000_0007,          8'h80, 64'hAB00_0000_0000_0000, 1);
    op("SD@0",   0, 1, 3'b011, 64'h0011_2233_4455_6677, 0, 0,  64'h8000_0000,         0, 12'h0,   64'h0,     64'h0,                  64'h8000_0000,          8'hFF, 64'h0011_2233_4455_6677, 1);
    drain();

    // Request stalled 4 cycles by the memory.
    mem_req_wait = 4;
    op("SW@4stall", 0, 1, 3'b010, 64'h1122_3344,        0, 0,  64'h8000_0004,         0, 12'h0,   64'h0,     64'h0,                  64'h8000_0004,          8'hF0, 64'h1122_3344_0000_0000, 1);
    drain();
    mem_req_wait = 0;

    // LD held in DONE for 3 cycles while a SW waits upstream.
    ws_allowin = 1'b0;
    op("LD@8",   1, 0, 3'b011, 64'h0,                  1, 13, 64'h8000_0008,         1, 12'h341, 64'h5555,  64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'h00, 64'h0, 1);
    fork
      op("SW@10", 0, 1, 3'b010, 64'hCAFE_BABE,          0, 0,  64'h8000_0010,         0, 12'h0,   64'h0,     64'h0,                  64'h8000_0010,          8'h0F, 64'hCAFE_BABE, 1);
      begin
        cnt = 0;
        while (!ms_to_ws_valid && cnt < 50) begin
          @(negedge clk);
          cnt++;
        end
        if (cnt >= 50) fail_now("ld_done_timeout");
        repeat (3) @(negedge clk);
        ws_allowin = 1'b1;
      end
    join
    chk("sw_req_same_edge", 256'(req_valid), 256'(1));
    chk("sw_not_done_yet", 256'(ms_to_ws_valid), 256'(0));
    drain();

    // Reset while the stage sits in WAIT.
    mem_hold_rsp = 1'b1;
    op("LD-rst", 1, 0, 3'b011, 64'h0,                  1, 9,  64'h8000_0020,         0, 12'h0,   64'h0,     64'h0,                  64'h0,                  8'h00, 64'h0, 0);
    cnt = 0;
    while (!rsp_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) fail_now("wait_state_timeout");
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midwait_rst_req_valid", 256'(req_valid), 256'(0));
    chk("midwait_rst_ws_valid", 256'(ms_to_ws_valid), 256'(0));
    chk("midwait_rst_rsp_ready", 256'(rsp_ready), 256'(0));
    chk("midwait_rst_allowin", 256'(ms_allowin), 256'(1));
    @(negedge clk);
    rst_n        = 1'b1;
    mem_hold_rsp = 1'b0;
    #1;
    chk("post_rst_idle_req", 256'(req_valid), 256'(0));
    op("LW-post", 1, 0, 3'b010, 64'h0,                 1, 3,  64'h8000_0000,         0, 12'h0,   64'h0,     64'h0000_0000_7FFF_FFFF, 64'h7FFF_FFFF,          8'h00, 64'h0, 1);
    drain();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
